// File: rtl/register_bank.sv
// Small register file with one write port and two combinational read ports.
// The write port does LOAD/INC/DEC; carry and zero flags track the last executed write.
module register_bank #(
  parameter int unsigned         WIDTH       = 8,
  parameter int unsigned         DEPTH       = 4,
  parameter logic [WIDTH-1:0]    RESET_VALUE = '0,
  localparam int unsigned        ADDR_W      = $clog2(DEPTH)
) (
  input  logic                   mclk,
  input  logic                   reset,
  input  logic                   mclk_en,
  input  logic [1:0]             i_op,
  input  logic                   i_clear,
  input  logic [ADDR_W-1:0]      i_wr_addr,
  input  logic [WIDTH-1:0]       i_load_data,
  input  logic [ADDR_W-1:0]      i_rd_addr_a,
  input  logic [ADDR_W-1:0]      i_rd_addr_b,
  output logic [WIDTH-1:0]       o_data_a,
  output logic [WIDTH-1:0]       o_data_b,
  output logic                   o_carry,
  output logic                   o_zero,
  output logic [DEPTH*WIDTH-1:0] o_all
);

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_LOAD = 2'b01,
    OP_INC  = 2'b10,
    OP_DEC  = 2'b11
  } op_e;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_carry;
  logic             r_zero;

  op_e              w_op;
  logic [DEPTH-1:0] w_sel;
  logic             w_hit;
  logic [WIDTH-1:0] w_old;
  logic [WIDTH-1:0] w_next;
  logic             w_carry;
  logic             w_zero;

  assign w_op = op_e'(i_op);

  // Address decode by comparison keeps out-of-range addresses (non power-of-two
  // DEPTH) from selecting anything: writes are dropped and reads return 0.
  always_comb begin
    w_sel    = '0;
    w_old    = '0;
    o_data_a = '0;
    o_data_b = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_sel[i] = (i_wr_addr == ADDR_W'(i));
      if (w_sel[i])                     w_old    = r_mem[i];
      if (i_rd_addr_a == ADDR_W'(i))    o_data_a = r_mem[i];
      if (i_rd_addr_b == ADDR_W'(i))    o_data_b = r_mem[i];
    end
    w_hit = |w_sel;
  end

  always_comb begin
    w_next  = w_old;
    w_carry = r_carry;
    case (w_op)
      OP_LOAD: begin w_next = i_load_data;  w_carry = 1'b0;    end
      OP_INC:  begin w_next = w_old + 1'b1; w_carry = &w_old;  end
      OP_DEC:  begin w_next = w_old - 1'b1; w_carry = ~|w_old; end
      default: begin w_next = w_old;        w_carry = r_carry; end
    endcase
    w_zero = (w_next == '0);
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= RESET_VALUE;
      r_carry <= 1'b0;
      r_zero  <= (RESET_VALUE == '0);
    end else if (mclk_en) begin
      if (i_clear) begin
        for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        r_carry <= 1'b0;
        r_zero  <= 1'b1;
      end else if (w_op != OP_HOLD && w_hit) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (w_sel[i]) r_mem[i] <= w_next;
        end
        r_carry <= w_carry;
        r_zero  <= w_zero;
      end
    end
  end

  always_comb begin
    o_all = '0;
    for (int unsigned i = 0; i < DEPTH; i++) o_all[i*WIDTH +: WIDTH] = r_mem[i];
  end

  assign o_carry = r_carry;
  assign o_zero  = r_zero;

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank: a DEPTH=4 instance (reset value 0) and a
// DEPTH=3 instance (reset value 0xA5) share stimulus; a behavioural model predicts both.
module tb_register_bank;

  logic       mclk = 1'b0;
  logic       reset, mclk_en, i_clear;
  logic [1:0] i_op, i_wr_addr, i_rd_addr_a, i_rd_addr_b;
  logic [7:0] i_load_data;

  logic [7:0]  a4, b4, a3, b3;
  logic        c4, z4, c3, z3;
  logic [31:0] all4;
  logic [23:0] all3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 mclk = ~mclk;

  register_bank #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(8'h00)) u_dut4 (
    .mclk(mclk), .reset(reset), .mclk_en(mclk_en), .i_op(i_op), .i_clear(i_clear),
    .i_wr_addr(i_wr_addr), .i_load_data(i_load_data),
    .i_rd_addr_a(i_rd_addr_a), .i_rd_addr_b(i_rd_addr_b),
    .o_data_a(a4), .o_data_b(b4), .o_carry(c4), .o_zero(z4), .o_all(all4)
  );

  register_bank #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'hA5)) u_dut3 (
    .mclk(mclk), .reset(reset), .mclk_en(mclk_en), .i_op(i_op), .i_clear(i_clear),
    .i_wr_addr(i_wr_addr), .i_load_data(i_load_data),
    .i_rd_addr_a(i_rd_addr_a), .i_rd_addr_b(i_rd_addr_b),
    .o_data_a(a3), .o_data_b(b3), .o_carry(c3), .o_zero(z3), .o_all(all3)
  );

  typedef struct {
    logic [31:0] all4; logic c4, z4; logic [7:0] a4, b4;
    logic [23:0] all3; logic c3, z3; logic [7:0] a3, b3;
  } exp_t;

  exp_t sb[$];

  // Model state: index 0 is the DEPTH=4 instance, index 1 the DEPTH=3 instance.
  logic [7:0] mm [2][4];
  logic       mc [2];
  logic       mz [2];
  bit         started = 0;
  string      phase = "reset";

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", phase, tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rd(input int k, input int d, input logic [1:0] a);
    return (int'(a) < d) ? mm[k][a] : 8'h00;
  endfunction

  task automatic step(input int k, input int d, input logic [7:0] rv,
                      input logic rst, input logic en, input logic [1:0] op,
                      input logic clr, input logic [1:0] wa, input logic [7:0] ld);
    if (rst) begin
      for (int i = 0; i < d; i++) mm[k][i] = rv;
      mc[k] = 1'b0;
      mz[k] = (rv == 8'h00);
    end else if (en) begin
      if (clr) begin
        for (int i = 0; i < d; i++) mm[k][i] = 8'h00;
        mc[k] = 1'b0;
        mz[k] = 1'b1;
      end else if (int'(wa) < d && op != 2'b00) begin
        case (op)
          2'b01: begin mm[k][wa] = ld; mc[k] = 1'b0; end
          2'b10: begin mc[k] = (mm[k][wa] == 8'hFF); mm[k][wa] = mm[k][wa] + 8'h01; end
          default: begin mc[k] = (mm[k][wa] == 8'h00); mm[k][wa] = mm[k][wa] - 8'h01; end
        endcase
        mz[k] = (mm[k][wa] == 8'h00);
      end
    end
  endtask

  task automatic cyc(input logic rst, input logic en, input logic [1:0] op, input logic clr,
                     input logic [1:0] wa, input logic [7:0] ld,
                     input logic [1:0] ra, input logic [1:0] rb);
    exp_t e;
    @(negedge mclk);
    reset = rst; mclk_en = en; i_op = op; i_clear = clr;
    i_wr_addr = wa; i_load_data = ld; i_rd_addr_a = ra; i_rd_addr_b = rb;
    #1;
    // Before the edge the read ports must still show the old contents.
    if (started) begin
      check("rdw_a4", a4, rd(0, 4, ra));
      check("rdw_b3", b3, rd(1, 3, rb));
    end
    step(0, 4, 8'h00, rst, en, op, clr, wa, ld);
    step(1, 3, 8'hA5, rst, en, op, clr, wa, ld);
    started = 1;
    e.all4 = {mm[0][3], mm[0][2], mm[0][1], mm[0][0]};
    e.all3 = {mm[1][2], mm[1][1], mm[1][0]};
    e.c4 = mc[0]; e.z4 = mz[0]; e.a4 = rd(0, 4, ra); e.b4 = rd(0, 4, rb);
    e.c3 = mc[1]; e.z3 = mz[1]; e.a3 = rd(1, 3, ra); e.b3 = rd(1, 3, rb);
    sb.push_back(e);
    @(posedge mclk);
    #1;
    e = sb.pop_front();
    check("all4", all4, e.all4); check("c4", c4, e.c4); check("z4", z4, e.z4);
    check("a4", a4, e.a4);       check("b4", b4, e.b4);
    check("all3", all3, e.all3); check("c3", c3, e.c3); check("z3", z3, e.z3);
    check("a3", a3, e.a3);       check("b3", b3, e.b3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] pick [5];
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) mm[k][i] = 8'h00;
    mc[0] = 0; mc[1] = 0; mz[0] = 1; mz[1] = 1;

    phase = "reset";
    cyc(1, 0, 2'b00, 0, 0, 8'h00, 0, 2);
    check("rst_all4_const", all4, 32'h0000_0000);
    check("rst_all3_const", all3, 24'hA5A5A5);
    check("rst_z4_const", z4, 1'b1);
    check("rst_z3_const", z3, 1'b0);

    phase = "load";
    cyc(0, 1, 2'b01, 0, 2, 8'h5A, 2, 0);
    check("load_a4_const", a4, 8'h5A);

    phase = "incwrap";
    cyc(0, 1, 2'b01, 0, 1, 8'hFE, 1, 1);
    cyc(0, 1, 2'b10, 0, 1, 8'h00, 1, 1);
    cyc(0, 1, 2'b10, 0, 1, 8'h00, 1, 1);
    check("wrap_c4_const", c4, 1'b1);
    cyc(0, 1, 2'b11, 0, 1, 8'h00, 1, 1);
    check("borrow_a4_const", a4, 8'hFF);

    phase = "enable";
    cyc(0, 1, 2'b10, 0, 0, 8'h00, 0, 0);
    cyc(0, 0, 2'b10, 0, 0, 8'h00, 0, 0);
    cyc(0, 1, 2'b10, 0, 0, 8'h00, 0, 0);
    cyc(0, 0, 2'b10, 0, 0, 8'h00, 0, 0);
    check("en_a4_const", a4, 8'h02);

    phase = "clear";
    cyc(0, 1, 2'b01, 1, 3, 8'h33, 3, 3);

    phase = "oob";
    cyc(0, 1, 2'b01, 0, 0, 8'h12, 0, 3);
    cyc(0, 1, 2'b01, 0, 3, 8'h77, 0, 3);
    cyc(0, 1, 2'b01, 0, 3, 8'h00, 3, 3);
    cyc(0, 1, 2'b10, 0, 3, 8'h00, 3, 3);
    cyc(0, 1, 2'b00, 0, 0, 8'h00, 3, 0);

    phase = "midreset";
    cyc(0, 1, 2'b01, 0, 0, 8'h10, 0, 0);
    cyc(0, 1, 2'b10, 0, 0, 8'h00, 0, 0);
    cyc(1, 0, 2'b10, 0, 0, 8'h00, 0, 0);
    check("mr_a4_const", a4, 8'h00);
    cyc(0, 1, 2'b10, 0, 0, 8'h00, 0, 1);

    phase = "random";
    pick[0] = 8'h00; pick[1] = 8'hFF; pick[2] = 8'hFE; pick[3] = 8'h01;
    for (int n = 0; n < 60; n++) begin
      pick[4] = 8'($urandom);
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
          2'($urandom_range(0, 3)), $urandom_range(0, 9) == 0,
          2'($urandom_range(0, 3)), pick[$urandom_range(0, 4)],
          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    phase = "end";
    check("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
